// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port ids, the stage-B request
// record and the lock-state encoding used when DMEM_ARBITER_LOCK_EN is set.
package dmem_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU  = 1'b0;
  localparam port_id_t PORT_LOAD = 1'b1;

  // Widths of the stage-B record; the top-level ADDR_W/DATA_W default to these.
  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef struct packed {
    logic                   valid;
    port_id_t               port;
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } breq_t;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_CPU  = 2'd1,
    LOCK_LOAD = 2'd2
  } lock_state_t;

  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic with last_grant register.
// With DMEM_ARBITER_LOCK_EN defined, a lock owner excludes the other port.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
`ifdef DMEM_ARBITER_LOCK_EN
  input  logic lock0,
  input  logic lock1,
`endif
  output logic gnt0,
  output logic gnt1
);

  port_id_t last_q, last_d;
  logic     rr_g0, rr_g1;

  // Plain round-robin choice: the port that did not win last time wins a tie.
  always_comb begin
    rr_g0 = 1'b0;
    rr_g1 = 1'b0;
    if (req0 && req1) begin
      if (last_q == other_port(PORT_CPU)) rr_g0 = 1'b1;
      else                                rr_g1 = 1'b1;
    end else begin
      rr_g0 = req0;
      rr_g1 = req1;
    end
  end

`ifdef DMEM_ARBITER_LOCK_EN
  lock_state_t lock_q, lock_d;

  // Lock state register; reset clears any lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= LOCK_NONE;
    else        lock_q <= lock_d;
  end

  // Grant selection under lock, and lock next state.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    lock_d = lock_q;
    case (lock_q)
      LOCK_CPU:  gnt0 = req0;
      LOCK_LOAD: gnt1 = req1;
      default: begin
        gnt0 = rr_g0;
        gnt1 = rr_g1;
      end
    endcase
    // An owner that stops requesting for a full cycle gives up the lock.
    if ((lock_q == LOCK_CPU && !req0) || (lock_q == LOCK_LOAD && !req1))
      lock_d = LOCK_NONE;
    if (gnt0) lock_d = lock0 ? LOCK_CPU  : LOCK_NONE;
    if (gnt1) lock_d = lock1 ? LOCK_LOAD : LOCK_NONE;
  end
`else
  // Grant is the round-robin choice.
  always_comb begin
    gnt0 = rr_g0;
    gnt1 = rr_g1;
  end
`endif

  // last_grant next value: follows the winner, unchanged when idle.
  always_comb begin
    last_d = last_q;
    if (gnt0)      last_d = PORT_CPU;
    else if (gnt1) last_d = PORT_LOAD;
  end

  // last_grant register; resets to the loader so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_LOAD;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single data memory.
// Granted requests are registered (stage B) and drive the memory one cycle
// later; read data returns registered, two cycles after the grant.
// Optional macro DMEM_ARBITER_LOCK_EN adds lock0/lock1 inputs.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef DMEM_ARBITER_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  breq_t b_q;
  logic  any_gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
`ifdef DMEM_ARBITER_LOCK_EN
    .lock0 (lock0),
    .lock1 (lock1),
`endif
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign any_gnt = gnt0 | gnt1;

  // Stage-B register: valid every cycle, payload only on a grant so the
  // memory address and write data hold through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q <= '0;
    end else begin
      b_q.valid <= any_gnt;
      if (any_gnt) begin
        b_q.port  <= gnt1 ? PORT_LOAD : PORT_CPU;
        b_q.we    <= gnt1 ? we1 : we0;
        b_q.addr  <= DMEM_ADDR_W'(gnt1 ? addr1 : addr0);
        b_q.wdata <= DMEM_DATA_W'(gnt1 ? wdata1 : wdata0);
      end
    end
  end

  // Memory side driven straight from stage B; reset clears mem_we at once.
  assign mem_we    = b_q.valid & b_q.we;
  assign mem_addr  = ADDR_W'(b_q.addr);
  assign mem_wdata = DATA_W'(b_q.wdata);

  // Read response: capture memory data at the end of the B cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= b_q.valid & ~b_q.we & (b_q.port == PORT_CPU);
      rvalid1 <= b_q.valid & ~b_q.we & (b_q.port == PORT_LOAD);
      if (b_q.valid && !b_q.we && b_q.port == PORT_CPU)  rdata0 <= mem_rdata;
      if (b_q.valid && !b_q.we && b_q.port == PORT_LOAD) rdata1 <= mem_rdata;
    end
  end

endmodule
